quick_spi_arbiter: RTL and testbench
====================================

QUICK_SPI_ARBITER -- requirements
Module: quick_spi_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQUESTERS, default 4, number of independent SPI transaction requesters.
REQ-002 SHALL have parameter OUTGOING_DATA_WIDTH, default 16, transmit word width per transaction.
REQ-003 SHALL have parameter INCOMING_DATA_WIDTH, default 8, receive word width per transaction.
REQ-004 SHALL have parameter NUMBER_OF_SLAVES, default 2, number of SPI slave selects; SEL_W = max(1, clog2(NUMBER_OF_SLAVES)).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1024, watchdog limit per phase, must be >= 2.
REQ-006 SHALL have the following ports; one clock; reset is asynchronous and active-high:
  clk  input  1  clock, all logic on rising edge
  reset  input  1  asynchronous active-high reset
  req  input  NUM_REQUESTERS  per-requester transaction request level
  req_data  input  NUM_REQUESTERS*OUTGOING_DATA_WIDTH  packed transmit words, requester i at slice i
  req_slave  input  NUM_REQUESTERS*SEL_W  packed target slave index per requester
  grant  output  NUM_REQUESTERS  one-hot owner of SPI master, all-zero when idle
  done  output  NUM_REQUESTERS  one-cycle completion pulse to owner
  error  output  NUM_REQUESTERS  one-cycle timeout pulse to owner
  resp_data  output  INCOMING_DATA_WIDTH  received word, valid while done is high
  spi_enable  output  1  start request to SPI master
  spi_outgoing_data  output  OUTGOING_DATA_WIDTH  latched transmit word to SPI master
  spi_slave  output  SEL_W  latched slave index to SPI master
  spi_busy  input  1  SPI master busy flag
  spi_incoming_data  input  INCOMING_DATA_WIDTH  SPI master receive word

Function
REQ-007 SHALL implement states IDLE, LAUNCH, RUN, COMPLETE, ABORT; all outputs registered.
REQ-008 IDLE: if any req bit high at a rising edge, SHALL select winner by round-robin starting at index (last_owner+1) mod NUM_REQUESTERS, wrapping; else remain IDLE.
REQ-009 On selection SHALL, at that same edge, set grant one-hot to winner, latch winner's req_data slice into spi_outgoing_data and req_slave slice into spi_slave, set spi_enable=1, clear watchdog, enter LAUNCH (grant/spi_enable visible 1 cycle after req sampled).
REQ-010 LAUNCH: on spi_busy=1 SHALL clear spi_enable, clear watchdog, enter RUN; otherwise increment watchdog.
REQ-011 RUN: spi_enable=0; on spi_busy=0 SHALL capture spi_incoming_data into resp_data, assert done[owner] for exactly one cycle, enter COMPLETE; otherwise increment watchdog.
REQ-012 COMPLETE: one cycle; at its end SHALL clear grant and done, set last_owner=owner, enter IDLE.
REQ-013 Watchdog reaching TIMEOUT_CYCLES-1 in LAUNCH or RUN SHALL force spi_enable=0, assert error[owner] for one cycle, enter ABORT; resp_data unchanged, done not asserted.
REQ-014 ABORT: one cycle; SHALL clear grant and error, update last_owner=owner, enter IDLE.
REQ-015 req, req_data, req_slave SHALL be ignored outside IDLE; req drop mid-transaction SHALL NOT abort it.
REQ-016 Requesters clear req during done/error cycle; req still high in following IDLE cycle SHALL be a new request subject to round-robin.
REQ-017 At most one grant, done, error bit SHALL ever be high; done and error never simultaneously.
REQ-018 spi_outgoing_data and spi_slave SHALL hold stable from LAUNCH entry until return to IDLE.
REQ-019 spi_busy=1 observed in IDLE SHALL be ignored (no grant change).

Reset
REQ-020 reset high SHALL immediately force: state IDLE, grant 0, done 0, error 0, spi_enable 0, resp_data 0, spi_outgoing_data 0, spi_slave 0, watchdog 0, last_owner NUM_REQUESTERS-1 (so requester 0 wins first).
REQ-021 Reset asserted mid-transaction SHALL abandon it without done or error pulse; after release, arbitration restarts from requester 0.

Verification
REQ-022 Single request: req=4'b0100, req_data[2]=16'hA55A, slave 1; SPI model busy 3 cycles after enable, returns 8'h3C -> grant=4'b0100, spi_outgoing_data=16'hA55A, spi_slave=1, done=4'b0100 one cycle with resp_data=8'h3C.
REQ-023 Round-robin fairness: req=4'b1111 held continuously after reset -> grant sequence 0,1,2,3,0, each separated by one IDLE cycle.
REQ-024 Wrap: last_owner=3, req=4'b1001 -> grant requester 0; next grant requester 3.
REQ-025 Launch timeout: TIMEOUT_CYCLES=8, spi_busy held 0 -> spi_enable high 7 cycles, error[owner] one pulse, grant cleared, no done.
REQ-026 Run timeout and reset: spi_busy stuck 1 -> error pulse after TIMEOUT_CYCLES; separate run asserting reset during RUN -> all outputs zero immediately, no done/error, next grant to requester 0.

Source files
------------

// File: rtl/quick_spi_arbiter_if.sv
// Request/grant and SPI-master control bundle for quick_spi_arbiter.
// The arbiter uses the slave modport; requesters and the SPI master model use master.
interface quick_spi_arbiter_if #(
    parameter int unsigned NUM_REQUESTERS      = 4,
    parameter int unsigned OUTGOING_DATA_WIDTH = 16,
    parameter int unsigned INCOMING_DATA_WIDTH = 8,
    parameter int unsigned NUMBER_OF_SLAVES    = 2
);
    localparam int unsigned SEL_W = (NUMBER_OF_SLAVES > 1) ? $clog2(NUMBER_OF_SLAVES) : 1;

    logic [NUM_REQUESTERS-1:0]                     req;
    logic [NUM_REQUESTERS*OUTGOING_DATA_WIDTH-1:0] req_data;
    logic [NUM_REQUESTERS*SEL_W-1:0]               req_slave;
    logic [NUM_REQUESTERS-1:0]                     grant;
    logic [NUM_REQUESTERS-1:0]                     done;
    logic [NUM_REQUESTERS-1:0]                     error;
    logic [INCOMING_DATA_WIDTH-1:0]                resp_data;
    logic                                          spi_enable;
    logic [OUTGOING_DATA_WIDTH-1:0]                spi_outgoing_data;
    logic [SEL_W-1:0]                              spi_slave;
    logic                                          spi_busy;
    logic [INCOMING_DATA_WIDTH-1:0]                spi_incoming_data;

    modport slave (
        input  req, req_data, req_slave, spi_busy, spi_incoming_data,
        output grant, done, error, resp_data, spi_enable, spi_outgoing_data, spi_slave
    );

    modport master (
        output req, req_data, req_slave, spi_busy, spi_incoming_data,
        input  grant, done, error, resp_data, spi_enable, spi_outgoing_data, spi_slave
    );
endinterface

// File: rtl/quick_spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among several requesters,
// with a per-phase watchdog that aborts stalled launches or transfers.
module quick_spi_arbiter #(
    parameter int unsigned NUM_REQUESTERS      = 4,
    parameter int unsigned OUTGOING_DATA_WIDTH = 16,
    parameter int unsigned INCOMING_DATA_WIDTH = 8,
    parameter int unsigned NUMBER_OF_SLAVES    = 2,
    parameter int unsigned TIMEOUT_CYCLES      = 1024
) (
    input  logic               clk,
    input  logic               reset,
    quick_spi_arbiter_if.slave bus
);
    localparam int unsigned NR    = NUM_REQUESTERS;
    localparam int unsigned ODW   = OUTGOING_DATA_WIDTH;
    localparam int unsigned IDW   = INCOMING_DATA_WIDTH;
    localparam int unsigned SEL_W = (NUMBER_OF_SLAVES > 1) ? $clog2(NUMBER_OF_SLAVES) : 1;
    localparam int unsigned OWN_W = (NR > 1) ? $clog2(NR) : 1;
    localparam int unsigned WD_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    // Watchdog fires on the edge where it would step onto TIMEOUT_CYCLES-1.
    localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT_CYCLES - 2);
    localparam logic [OWN_W-1:0] LAST_RESET = OWN_W'(NR - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_COMPLETE,
        S_ABORT
    } state_e;

    state_e           state_q, state_d;
    logic [NR-1:0]    grant_q, grant_d;
    logic [NR-1:0]    done_q,  done_d;
    logic [NR-1:0]    error_q, error_d;
    logic [IDW-1:0]   resp_q,  resp_d;
    logic             en_q,    en_d;
    logic [ODW-1:0]   tx_q,    tx_d;
    logic [SEL_W-1:0] sel_q,   sel_d;
    logic [WD_W-1:0]  wd_q,    wd_d;
    logic [OWN_W-1:0] owner_q, owner_d;
    logic [OWN_W-1:0] last_q,  last_d;

    logic [ODW-1:0]   tx_arr_c  [NR];
    logic [SEL_W-1:0] sel_arr_c [NR];
    logic             win_valid_c;
    logic [OWN_W-1:0] win_idx_c;

    for (genvar g = 0; g < NR; g++) begin : g_unpack
        assign tx_arr_c[g]  = bus.req_data[g*ODW +: ODW];
        assign sel_arr_c[g] = bus.req_slave[g*SEL_W +: SEL_W];
    end

    // Round-robin search starting just after the previous owner.
    always_comb begin
        int unsigned      cand;
        logic [OWN_W-1:0] cand_idx;
        win_valid_c = 1'b0;
        win_idx_c   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int unsigned k = 1; k <= NR; k++) begin
            cand     = (32'(last_q) + k) % NR;
            cand_idx = OWN_W'(cand);
            if (!win_valid_c && bus.req[cand_idx]) begin
                win_valid_c = 1'b1;
                win_idx_c   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        error_d = '0;
        resp_d  = resp_q;
        en_d    = en_q;
        tx_d    = tx_q;
        sel_d   = sel_q;
        wd_d    = wd_q;
        owner_d = owner_q;
        last_d  = last_q;

        case (state_q)
            S_IDLE: begin
                if (win_valid_c) begin
                    grant_d = NR'(1) << win_idx_c;
                    owner_d = win_idx_c;
                    tx_d    = tx_arr_c[win_idx_c];
                    sel_d   = sel_arr_c[win_idx_c];
                    en_d    = 1'b1;
                    wd_d    = '0;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (bus.spi_busy) begin
                    en_d    = 1'b0;
                    wd_d    = '0;
                    state_d = S_RUN;
                end else if (wd_q == WD_LAST) begin
                    en_d    = 1'b0;
                    error_d = grant_q;
                    state_d = S_ABORT;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_RUN: begin
                if (!bus.spi_busy) begin
                    resp_d  = bus.spi_incoming_data;
                    done_d  = grant_q;
                    state_d = S_COMPLETE;
                end else if (wd_q == WD_LAST) begin
                    error_d = grant_q;
                    state_d = S_ABORT;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_COMPLETE, S_ABORT: begin
                grant_d = '0;
                last_d  = owner_q;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = '0;
                en_d    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            error_q <= '0;
            resp_q  <= '0;
            en_q    <= 1'b0;
            tx_q    <= '0;
            sel_q   <= '0;
            wd_q    <= '0;
            owner_q <= '0;
            last_q  <= LAST_RESET;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            error_q <= error_d;
            resp_q  <= resp_d;
            en_q    <= en_d;
            tx_q    <= tx_d;
            sel_q   <= sel_d;
            wd_q    <= wd_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    assign bus.grant             = grant_q;
    assign bus.done              = done_q;
    assign bus.error             = error_q;
    assign bus.resp_data         = resp_q;
    assign bus.spi_enable        = en_q;
    assign bus.spi_outgoing_data = tx_q;
    assign bus.spi_slave         = sel_q;
endmodule

// File: tb/tb_quick_spi_arbiter.sv
// Directed bench for quick_spi_arbiter: single transfer, round-robin order,
// wrap-around, launch/run watchdog aborts and reset during a transfer.
module tb_quick_spi_arbiter;
    localparam int unsigned NR  = 4;
    localparam int unsigned ODW = 16;
    localparam int unsigned IDW = 8;
    localparam int unsigned NS  = 2;
    localparam int unsigned TO  = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    quick_spi_arbiter_if #(
        .NUM_REQUESTERS     (NR),
        .OUTGOING_DATA_WIDTH(ODW),
        .INCOMING_DATA_WIDTH(IDW),
        .NUMBER_OF_SLAVES   (NS)
    ) bus ();

    quick_spi_arbiter #(
        .NUM_REQUESTERS     (NR),
        .OUTGOING_DATA_WIDTH(ODW),
        .INCOMING_DATA_WIDTH(IDW),
        .NUMBER_OF_SLAVES   (NS),
        .TIMEOUT_CYCLES     (TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;
    logic [7:0] last_rx = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // One full transfer for requester idx, entered from an IDLE cycle.
    task automatic xact(input int idx, input logic [7:0] rx);
        logic [3:0] g;
        g = 4'(1 << idx);
        step();
        check_eq("rr_grant", 32'(bus.grant), 32'(g));
        check_eq("rr_enable", 32'(bus.spi_enable), 32'd1);
        check_eq("rr_tx", 32'(bus.spi_outgoing_data), 32'(16'hC0D0 + 16'(idx)));
        check_eq("rr_slave", 32'(bus.spi_slave), 32'(idx % 2));
        bus.spi_busy = 1'b1;
        step();
        bus.spi_busy = 1'b0;
        bus.spi_incoming_data = rx;
        step();
        check_eq("rr_done", 32'(bus.done), 32'(g));
        check_eq("rr_resp", 32'(bus.resp_data), 32'(rx));
        last_rx = rx;
        step();
        check_eq("rr_idle_gap", 32'(bus.grant), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        reset = 1'b1;
        bus.req = '0;
        bus.req_data = '0;
        bus.req_slave = '0;
        bus.spi_busy = 1'b0;
        bus.spi_incoming_data = '0;
        step();
        step();

        // Reset state
        check_eq("rst_grant", 32'(bus.grant), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_error", 32'(bus.error), 32'd0);
        check_eq("rst_enable", 32'(bus.spi_enable), 32'd0);
        check_eq("rst_resp", 32'(bus.resp_data), 32'd0);
        check_eq("rst_tx", 32'(bus.spi_outgoing_data), 32'd0);
        check_eq("rst_slave", 32'(bus.spi_slave), 32'd0);
        reset = 1'b0;
        step();

        // Single request from requester 2, busy for three cycles
        bus.req = 4'b0100;
        bus.req_data = 64'h0000_A55A_0000_0000;
        bus.req_slave = 4'b0100;
        step();
        check_eq("one_grant", 32'(bus.grant), 32'h4);
        check_eq("one_enable", 32'(bus.spi_enable), 32'd1);
        check_eq("one_tx", 32'(bus.spi_outgoing_data), 32'hA55A);
        check_eq("one_slave", 32'(bus.spi_slave), 32'd1);
        bus.req = '0;
        bus.req_data = '0;
        bus.req_slave = '0;
        bus.spi_busy = 1'b1;
        step();
        check_eq("one_run_enable", 32'(bus.spi_enable), 32'd0);
        check_eq("one_run_grant", 32'(bus.grant), 32'h4);
        step();
        step();
        check_eq("one_run_done", 32'(bus.done), 32'd0);
        check_eq("one_tx_hold", 32'(bus.spi_outgoing_data), 32'hA55A);
        bus.spi_busy = 1'b0;
        bus.spi_incoming_data = 8'h3C;
        step();
        check_eq("one_done", 32'(bus.done), 32'h4);
        check_eq("one_resp", 32'(bus.resp_data), 32'h3C);
        check_eq("one_error", 32'(bus.error), 32'd0);
        step();
        check_eq("one_done_clr", 32'(bus.done), 32'd0);
        check_eq("one_grant_clr", 32'(bus.grant), 32'd0);

        // Busy while idle must not start anything
        bus.spi_busy = 1'b1;
        step();
        step();
        check_eq("idle_busy_grant", 32'(bus.grant), 32'd0);
        check_eq("idle_busy_enable", 32'(bus.spi_enable), 32'd0);
        bus.spi_busy = 1'b0;

        // Round-robin with all requesters held after reset
        apply_reset();
        bus.req = 4'b1111;
        bus.req_data = 64'hC0D3_C0D2_C0D1_C0D0;
        bus.req_slave = 4'b1010;
        xact(0, 8'h11);
        xact(1, 8'h22);
        xact(2, 8'h33);
        xact(3, 8'h44);
        xact(0, 8'h55);

        // Wrap-around with two requesters at the ends
        bus.req = 4'b1001;
        xact(3, 8'h66);
        xact(0, 8'h77);
        xact(3, 8'h88);

        // Launch timeout: SPI master never goes busy
        bus.req = 4'b0001;
        step();
        check_eq("lto_grant", 32'(bus.grant), 32'h1);
        check_eq("lto_enable", 32'(bus.spi_enable), 32'd1);
        bus.req = '0;
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.spi_enable) cnt++;
            else break;
        end
        check_eq("lto_enable_cycles", 32'(cnt), 32'd7);
        check_eq("lto_error", 32'(bus.error), 32'h1);
        check_eq("lto_no_done", 32'(bus.done), 32'd0);
        check_eq("lto_resp_kept", 32'(bus.resp_data), 32'(last_rx));
        step();
        check_eq("lto_grant_clr", 32'(bus.grant), 32'd0);
        check_eq("lto_error_clr", 32'(bus.error), 32'd0);

        // Run timeout: SPI master stuck busy; requester 1 wins after owner 0
        bus.req = 4'b0010;
        step();
        check_eq("rto_grant", 32'(bus.grant), 32'h2);
        bus.req = '0;
        bus.spi_busy = 1'b1;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            cnt++;
            if (bus.error != '0) break;
        end
        check_eq("rto_cycles", 32'(cnt), 32'd8);
        check_eq("rto_error", 32'(bus.error), 32'h2);
        check_eq("rto_no_done", 32'(bus.done), 32'd0);
        bus.spi_busy = 1'b0;
        step();
        check_eq("rto_grant_clr", 32'(bus.grant), 32'd0);
        check_eq("rto_error_clr", 32'(bus.error), 32'd0);

        // Reset during RUN abandons the transfer
        bus.req = 4'b0100;
        step();
        check_eq("rrst_grant", 32'(bus.grant), 32'h4);
        bus.req = '0;
        bus.spi_busy = 1'b1;
        step();
        step();
        reset = 1'b1;
        #1;
        check_eq("rrst_grant_zero", 32'(bus.grant), 32'd0);
        check_eq("rrst_enable_zero", 32'(bus.spi_enable), 32'd0);
        check_eq("rrst_resp_zero", 32'(bus.resp_data), 32'd0);
        check_eq("rrst_tx_zero", 32'(bus.spi_outgoing_data), 32'd0);
        check_eq("rrst_slave_zero", 32'(bus.spi_slave), 32'd0);
        check_eq("rrst_done_zero", 32'(bus.done), 32'd0);
        check_eq("rrst_error_zero", 32'(bus.error), 32'd0);
        bus.spi_busy = 1'b0;
        step();
        step();
        reset = 1'b0;
        bus.req = 4'b1111;
        step();
        check_eq("rrst_next_grant", 32'(bus.grant), 32'h1);
        check_eq("rrst_next_tx", 32'(bus.spi_outgoing_data), 32'hC0D0);
        bus.req = '0;
        bus.spi_busy = 1'b1;
        step();
        bus.spi_busy = 1'b0;
        bus.spi_incoming_data = 8'h99;
        step();
        check_eq("rrst_next_done", 32'(bus.done), 32'h1);
        check_eq("rrst_next_resp", 32'(bus.resp_data), 32'h99);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
